// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipe: forwarding, load-use bubbles, branch/jump flushes, dmem freeze.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_id_use_rs,
    input  logic        i_id_use_rt,
    input  logic        i_id_jump,
    input  logic [4:0]  i_ex_rs,
    input  logic [4:0]  i_ex_rt,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_regwrite,
    input  logic        i_ex_memtoreg,
    input  logic        i_ex_br_taken,
    input  logic [4:0]  i_mem_rd,
    input  logic        i_mem_regwrite,
    input  logic [4:0]  i_wb_rd,
    input  logic        i_wb_regwrite,
    input  logic        i_dmem_req,
    input  logic        i_dmem_ready,
    output logic        o_stall_pc,
    output logic        o_stall_ifid,
    output logic        o_flush_ifid,
    output logic        o_flush_idex,
    output logic        o_freeze,
    output logic [1:0]  o_fwd_a,
    output logic [1:0]  o_fwd_b,
    output logic        o_mem_err,
    output logic [31:0] o_perf_stalls,
    output logic [31:0] o_perf_flushes
);

    typedef enum logic [1:0] {S_RUN, S_LU, S_MWAIT} state_t;

    state_t      r_state, w_state_next;
    state_t      r_ret, w_ret_next;
    logic [3:0]  r_lu_cnt, w_lu_cnt_next;
    logic [15:0] r_wait_cnt, w_wait_cnt_next;
    logic        r_mem_err, w_mem_err_next;
    logic        r_abort, w_abort_next;

    logic [4:0]  w_ex_src [2];
    logic [1:0]  w_fwd [2];
    logic        w_lu_hit, w_mem_hold;
    logic        w_stall_pc, w_stall_ifid, w_flush_ifid, w_flush_idex, w_freeze;

    assign w_ex_src[0] = i_ex_rs;
    assign w_ex_src[1] = i_ex_rt;

    // EX/MEM result is younger than MEM/WB, so it must win.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_fwd[gi] =
                (i_mem_regwrite && i_mem_rd != 5'd0 && i_mem_rd == w_ex_src[gi]) ? 2'b10 :
                (i_wb_regwrite  && i_wb_rd  != 5'd0 && i_wb_rd  == w_ex_src[gi]) ? 2'b01 :
                                                                                 2'b00;
        end
    endgenerate

    assign w_lu_hit = i_ex_memtoreg && i_ex_regwrite && (i_ex_rd != 5'd0) &&
                      ((i_id_use_rs && i_ex_rd == i_id_rs) || (i_id_use_rt && i_ex_rd == i_id_rt));
    assign w_mem_hold = i_dmem_req && !i_dmem_ready && !r_abort;

    always_comb begin
        w_state_next    = r_state;
        w_ret_next      = r_ret;
        w_lu_cnt_next   = r_lu_cnt;
        w_wait_cnt_next = r_wait_cnt;
        w_mem_err_next  = r_mem_err;
        w_abort_next    = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_mem_hold) begin
                    w_state_next    = S_MWAIT;
                    w_ret_next      = S_RUN;
                    w_wait_cnt_next = 16'd1;
                end else if (w_lu_hit && !i_ex_br_taken && LOAD_BUBBLES > 1) begin
                    w_state_next  = S_LU;
                    w_lu_cnt_next = 4'(LOAD_BUBBLES - 1);
                end
            end
            S_LU: begin
                if (w_mem_hold) begin
                    w_state_next    = S_MWAIT;
                    w_ret_next      = S_LU;
                    w_wait_cnt_next = 16'd1;
                end else if (i_ex_br_taken) begin
                    w_state_next  = S_RUN;
                    w_lu_cnt_next = 4'd0;
                end else begin
                    w_lu_cnt_next = r_lu_cnt - 4'd1;
                    if (r_lu_cnt == 4'd1) w_state_next = S_RUN;
                end
            end
            S_MWAIT: begin
                if (!w_mem_hold) begin
                    w_state_next    = r_ret;
                    w_wait_cnt_next = 16'd0;
                end else if (r_wait_cnt == 16'(MEM_TIMEOUT - 1)) begin
                    // Abort drops mem_hold for one cycle so the pipe can drain the dead access.
                    w_mem_err_next = 1'b1;
                    w_abort_next   = 1'b1;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 16'd1;
                end
            end
            default: w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_ret      <= S_RUN;
            r_lu_cnt   <= 4'd0;
            r_wait_cnt <= 16'd0;
            r_mem_err  <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ret      <= w_ret_next;
            r_lu_cnt   <= w_lu_cnt_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_mem_err  <= w_mem_err_next;
            r_abort    <= w_abort_next;
        end
    end

    always_comb begin
        w_stall_pc   = 1'b0;
        w_stall_ifid = 1'b0;
        w_flush_ifid = 1'b0;
        w_flush_idex = 1'b0;
        w_freeze     = 1'b0;
        if (rst) begin
            w_freeze = 1'b0;
        end else if (w_mem_hold) begin
            w_freeze     = 1'b1;
            w_stall_pc   = 1'b1;
            w_stall_ifid = 1'b1;
        end else if (i_ex_br_taken) begin
            w_flush_ifid = 1'b1;
            w_flush_idex = 1'b1;
        end else if (w_lu_hit || r_state == S_LU) begin
            w_stall_pc   = 1'b1;
            w_stall_ifid = 1'b1;
            w_flush_idex = 1'b1;
        end else if (i_id_jump) begin
            w_flush_ifid = 1'b1;
        end
    end

    assign o_stall_pc   = w_stall_pc;
    assign o_stall_ifid = w_stall_ifid;
    assign o_flush_ifid = w_flush_ifid;
    assign o_flush_idex = w_flush_idex;
    assign o_freeze     = w_freeze;
    assign o_fwd_a      = rst ? 2'b00 : w_fwd[0];
    assign o_fwd_b      = rst ? 2'b00 : w_fwd[1];
    assign o_mem_err    = r_mem_err;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stalls, r_perf_flushes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stalls  <= 32'd0;
            r_perf_flushes <= 32'd0;
        end else begin
            r_perf_stalls  <= r_perf_stalls + 32'(w_stall_pc);
            r_perf_flushes <= r_perf_flushes + 32'(w_flush_ifid | w_flush_idex);
        end
    end

    assign o_perf_stalls  = r_perf_stalls;
    assign o_perf_flushes = r_perf_flushes;
`else
    assign o_perf_stalls  = 32'd0;
    assign o_perf_flushes = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with LOAD_BUBBLES=1/MEM_TIMEOUT=64, one with 3/8, sharing stimulus.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic id_use_rs, id_use_rt, id_jump, ex_regwrite, ex_memtoreg, ex_br_taken;
    logic mem_regwrite, wb_regwrite, dmem_req, dmem_ready;

    logic stall_pc_1, stall_ifid_1, flush_ifid_1, flush_idex_1, freeze_1, mem_err_1;
    logic [1:0] fwd_a_1, fwd_b_1;
    logic [31:0] perf_stalls_1, perf_flushes_1;
    logic stall_pc_3, stall_ifid_3, flush_ifid_3, flush_idex_3, freeze_3, mem_err_3;
    logic [1:0] fwd_a_3, fwd_b_3;
    logic [31:0] perf_stalls_3, perf_flushes_3;

    logic [4:0] ctl1, ctl3;
    assign ctl1 = {stall_pc_1, stall_ifid_1, flush_ifid_1, flush_idex_1, freeze_1};
    assign ctl3 = {stall_pc_3, stall_ifid_3, flush_ifid_3, flush_idex_3, freeze_3};

    int errors;
    int checks;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(64)) u_lb1 (
        .clk(clk), .rst(rst),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
        .i_id_jump(id_jump), .i_ex_rs(ex_rs), .i_ex_rt(ex_rt), .i_ex_rd(ex_rd),
        .i_ex_regwrite(ex_regwrite), .i_ex_memtoreg(ex_memtoreg), .i_ex_br_taken(ex_br_taken),
        .i_mem_rd(mem_rd), .i_mem_regwrite(mem_regwrite), .i_wb_rd(wb_rd), .i_wb_regwrite(wb_regwrite),
        .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
        .o_stall_pc(stall_pc_1), .o_stall_ifid(stall_ifid_1), .o_flush_ifid(flush_ifid_1),
        .o_flush_idex(flush_idex_1), .o_freeze(freeze_1), .o_fwd_a(fwd_a_1), .o_fwd_b(fwd_b_1),
        .o_mem_err(mem_err_1), .o_perf_stalls(perf_stalls_1), .o_perf_flushes(perf_flushes_1)
    );

    hazard_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(8)) u_lb3 (
        .clk(clk), .rst(rst),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
        .i_id_jump(id_jump), .i_ex_rs(ex_rs), .i_ex_rt(ex_rt), .i_ex_rd(ex_rd),
        .i_ex_regwrite(ex_regwrite), .i_ex_memtoreg(ex_memtoreg), .i_ex_br_taken(ex_br_taken),
        .i_mem_rd(mem_rd), .i_mem_regwrite(mem_regwrite), .i_wb_rd(wb_rd), .i_wb_regwrite(wb_regwrite),
        .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
        .o_stall_pc(stall_pc_3), .o_stall_ifid(stall_ifid_3), .o_flush_ifid(flush_ifid_3),
        .o_flush_idex(flush_idex_3), .o_freeze(freeze_3), .o_fwd_a(fwd_a_3), .o_fwd_b(fwd_b_3),
        .o_mem_err(mem_err_3), .o_perf_stalls(perf_stalls_3), .o_perf_flushes(perf_flushes_3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_jump = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwrite = 0; ex_memtoreg = 0; ex_br_taken = 0;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // lw $3 in EX, ID instruction reads rt=$3
    task automatic load_use();
        ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 3; id_use_rt = 1; id_rt = 3;
    endtask

    task automatic do_reset();
        rst = 1; clr();
        nxt(); nxt();
        rst = 0;
    endtask

    int exp_stalls, exp_flushes;

    initial begin
        errors = 0; checks = 0;
        clr(); rst = 1;
        // Outputs stay low in reset even with forwarding/hazard inputs active
        mem_regwrite = 1; mem_rd = 5; ex_rs = 5; load_use(); id_jump = 1; ex_br_taken = 1;
        smp();
        chk("rst_fwd_a", 32'(fwd_a_1), 32'd0);
        chk("rst_ctl", 32'(ctl1), 32'd0);
        chk("rst_mem_err", 32'(mem_err_1), 32'd0);
        chk("rst_perf_stalls", perf_stalls_1, 32'd0);
        chk("rst_perf_flushes", perf_flushes_3, 32'd0);
        nxt(); clr(); rst = 0;

        // Forwarding
        mem_rd = 5; wb_rd = 5; mem_regwrite = 1; wb_regwrite = 1; ex_rs = 5; ex_rt = 6;
        smp();
        chk("fwd_a_exmem", 32'(fwd_a_1), 32'h2);
        chk("fwd_b_none", 32'(fwd_b_1), 32'h0);
        chk("fwd_ctl_idle", 32'(ctl1), 32'd0);
        nxt(); mem_regwrite = 0;
        smp(); chk("fwd_a_memwb", 32'(fwd_a_1), 32'h1);
        nxt(); ex_rs = 0; mem_rd = 0; wb_rd = 0; mem_regwrite = 1;
        smp(); chk("fwd_a_r0", 32'(fwd_a_1), 32'h0);
        nxt(); mem_rd = 7; wb_rd = 7; ex_rt = 7;
        smp(); chk("fwd_b_priority", 32'(fwd_b_1), 32'h2);
        nxt(); clr();

        // Load-use, one bubble
        load_use();
        smp(); chk("lu1_bubble", 32'(ctl1), 32'b11010);
        nxt(); clr(); ex_rt = 3; mem_rd = 3; mem_regwrite = 1;
        smp();
        chk("lu1_after", 32'(ctl1), 32'd0);
        chk("lu1_fwd_b", 32'(fwd_b_1), 32'h2);
        nxt(); clr(); ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 0; id_use_rs = 1; id_rs = 0;
        smp(); chk("lu_r0", 32'(ctl1), 32'd0);
        nxt(); id_use_rs = 0; ex_rd = 3; id_rt = 3;
        smp(); chk("lu_nouse", 32'(ctl1), 32'd0);
        nxt();

        // Load-use, three bubbles
        do_reset();
        load_use();
        smp(); chk("lu3_b1", 32'(ctl3), 32'b11010);
        nxt(); clr();
        smp(); chk("lu3_b2", 32'(ctl3), 32'b11010);
        nxt();
        smp(); chk("lu3_b3", 32'(ctl3), 32'b11010);
        nxt();
        smp(); chk("lu3_done", 32'(ctl3), 32'd0);
        nxt();

        // Branch beats load-use and jump
        load_use(); id_jump = 1; ex_br_taken = 1;
        smp();
        chk("br_prio_lb3", 32'(ctl3), 32'b00110);
        chk("br_prio_lb1", 32'(ctl1), 32'b00110);
        nxt(); clr();
        smp(); chk("br_no_lu", 32'(ctl3), 32'd0);
        nxt(); id_jump = 1;
        smp(); chk("jump_flush", 32'(ctl3), 32'b00100);
        nxt(); clr();

        // Freeze in the middle of a load-use sequence
        load_use();
        smp(); chk("lufz_b1", 32'(ctl3), 32'b11010);
        nxt(); clr(); dmem_req = 1;
        for (int i = 0; i < 4; i++) begin
            smp(); chk("lufz_freeze", 32'(ctl3), 32'b11001);
            nxt();
        end
        dmem_ready = 1;
        smp(); chk("lufz_release", 32'(ctl3), 32'd0);
        nxt(); clr();
        smp(); chk("lufz_b2", 32'(ctl3), 32'b11010);
        nxt();
        smp(); chk("lufz_b3", 32'(ctl3), 32'b11010);
        nxt();
        smp(); chk("lufz_done", 32'(ctl3), 32'd0);
        nxt();

        // Ready on the first request cycle
        dmem_req = 1; dmem_ready = 1;
        smp();
        chk("dmem_fast_lb3", 32'(ctl3), 32'd0);
        chk("dmem_fast_lb1", 32'(ctl1), 32'd0);
        nxt(); clr();

        // Timeout (MEM_TIMEOUT=8 on u_lb3)
        do_reset();
        dmem_req = 1;
        for (int i = 1; i <= 8; i++) begin
            smp();
            chk("to_freeze", 32'(freeze_3), 32'd1);
            chk("to_no_err", 32'(mem_err_3), 32'd0);
            nxt();
        end
        smp();
        chk("to_abort_ctl", 32'(ctl3), 32'd0);
        chk("to_mem_err", 32'(mem_err_3), 32'd1);
        chk("to_lb1_still_frozen", 32'(freeze_1), 32'd1);
        nxt();
        for (int i = 10; i <= 17; i++) begin
            smp(); chk("to2_freeze", 32'(freeze_3), 32'd1);
            nxt();
        end
        smp(); chk("to2_abort", 32'(freeze_3), 32'd0);
        nxt();
        rst = 1;
        smp();
        chk("rst_mwait_ctl", 32'(ctl3), 32'd0);
        chk("rst_mem_err_clr", 32'(mem_err_3), 32'd0);
        nxt(); rst = 0; clr();
        smp(); chk("rst_mwait_run", 32'(ctl3), 32'd0);
        nxt();

        // Reset mid-LU drops the stall
        load_use();
        smp(); chk("rlu_b1", 32'(ctl3), 32'b11010);
        nxt(); clr(); rst = 1;
        smp(); chk("rlu_in_rst", 32'(ctl3), 32'd0);
        nxt(); rst = 0;
        smp(); chk("rlu_run", 32'(ctl3), 32'd0);
        nxt();

        // Perf counters (0 when the counters are not built)
`ifdef HAZARD_PERF_EN
        exp_stalls = 1; exp_flushes = 2;
`else
        exp_stalls = 0; exp_flushes = 0;
`endif
        do_reset();
        load_use();
        smp(); nxt(); clr(); ex_br_taken = 1;
        smp(); nxt(); clr();
        smp();
        chk("perf_stalls", perf_stalls_1, 32'(exp_stalls));
        chk("perf_flushes", perf_flushes_1, 32'(exp_flushes));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
